// File: rtl/run_pause_checker_pkg.sv
// Shared state encoding and error codes for the run/pause checker.
// Imported by the checker top.
package run_pause_checker_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RUN   = 2'b01;
  localparam logic [1:0] ERR_PAUSE = 2'b10;
  localparam logic [1:0] ERR_CNT   = 2'b11;

endpackage

// File: rtl/run_pause_checker_sat_counter.sv
// Saturating up-counter used for the checker statistics.
// Sticks at all-ones once reached.
module run_pause_checker_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_pause_checker.sv
// Locks onto a run/pause enable pattern and checks the count
// advances by one per enabled cycle; reports errors and wraps.
module run_pause_checker
  import run_pause_checker_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RUN_LEN   = 3,
  parameter int PAUSE_LEN = 2,
  parameter int STAT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              oe,
  input  logic [WIDTH-1:0]  q,
  output logic              locked,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] wrap_cnt
);

  localparam logic [2:0] RUN_L   = 3'(RUN_LEN);
  localparam logic [2:0] PAUSE_L = 3'(PAUSE_LEN);

  state_e           state_q, state_d;
  logic [2:0]       len_q, len_d;
  logic             prev_oe_q;
  logic [WIDTH-1:0] prev_q_q;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             locked_q, locked_d;

  logic             checked;
  logic [WIDTH-1:0] exp_q;
  logic             cnt_bad;
  logic             run_bad;
  logic             pause_bad;
  logic             any_err;
  logic             wrap_hit;
  logic [1:0]       code;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    run_bad    = 1'b0;
    pause_bad  = 1'b0;
    checked    = (state_q != SYNC);
    exp_q      = prev_q_q + WIDTH'(prev_oe_q);
    cnt_bad    = checked && (q != exp_q);
    unique case (state_q)
      SYNC: begin
        if (!oe) state_d = ARM;
      end
      ARM: begin
        if (oe) begin
          state_d = RUN;
          len_d   = 3'd1;
        end
      end
      RUN: begin
        if (oe) begin
          if (len_q == RUN_L) run_bad = 1'b1;
          else len_d = len_q + 3'd1;
        end else if (len_q < RUN_L) begin
          run_bad = 1'b1;
        end else begin
          state_d = PAUSE;
          len_d   = 3'd1;
        end
      end
      PAUSE: begin
        if (!oe) begin
          if (len_q == PAUSE_L) pause_bad = 1'b1;
          else len_d = len_q + 3'd1;
        end else if (len_q < PAUSE_L) begin
          pause_bad = 1'b1;
        end else begin
          state_d = RUN;
          len_d   = 3'd1;
        end
      end
      default: ;
    endcase

    any_err = cnt_bad | run_bad | pause_bad;
    if (any_err) begin
      state_d = SYNC;
      len_d   = 3'd0;
    end

    // Count mismatch dominates; run and pause errors are exclusive
    if (cnt_bad)        code = ERR_CNT;
    else if (run_bad)   code = ERR_RUN;
    else if (pause_bad) code = ERR_PAUSE;
    else                code = ERR_NONE;

    err_d      = err_q | any_err;
    err_code_d = (any_err && !err_q) ? code : err_code_q;
    locked_d   = (state_d == RUN) || (state_d == PAUSE);
    wrap_hit   = checked && prev_oe_q && (&prev_q_q) && (q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      len_q      <= 3'd0;
      prev_oe_q  <= 1'b0;
      prev_q_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      prev_oe_q  <= oe;
      prev_q_q   <= q;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      locked_q   <= locked_d;
    end
  end

  run_pause_checker_sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (any_err),
    .cnt   (err_cnt)
  );

  run_pause_checker_sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_hit),
    .cnt   (wrap_cnt)
  );

  assign locked   = locked_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_run_pause_checker.sv
// Scoreboard bench for run_pause_checker: a segment-based reference
// model predicts outputs per sample, a monitor compares them.
module tb_run_pause_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       oe;
  logic [3:0] q;
  logic       locked;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  always #5 clk = ~clk;

  run_pause_checker #(
    .WIDTH(4), .RUN_LEN(3), .PAUSE_LEN(2), .STAT_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .oe       (oe),
    .q        (q),
    .locked   (locked),
    .err      (err),
    .err_code (err_code),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  typedef struct packed {
    logic       locked;
    logic       err;
    logic [1:0] code;
    logic [7:0] ecnt;
    logic [7:0] wcnt;
  } obs_t;

  obs_t exp_fifo[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;

  // Reference model: stage 0 = unsynced, 1 = saw a low, 2 = locked.
  // In lock, seg counts consecutive samples at level lvl.
  int   m_stage;
  bit   m_lvl;
  int   m_seg;
  bit   m_poe;
  int   m_pq;
  bit   m_err;
  int   m_code;
  int   m_ecnt;
  int   m_wcnt;
  int   u_q;

  function automatic int lim(bit lv);
    return lv ? 3 : 2;
  endfunction

  function automatic void model_reset();
    m_stage = 0; m_lvl = 0; m_seg = 0;
    m_poe = 0; m_pq = 0;
    m_err = 0; m_code = 0; m_ecnt = 0; m_wcnt = 0;
  endfunction

  function automatic obs_t model(bit o, int qv);
    bit   ce;
    bit   pe;
    int   c;
    obs_t r;
    ce = 0;
    pe = 0;
    c  = 0;
    if (m_stage != 0) begin
      if (qv != ((m_pq + int'(m_poe)) % 16)) ce = 1;
      if (m_poe && m_pq == 15 && qv == 0 && m_wcnt < 255) m_wcnt++;
    end
    if (m_stage == 2) begin
      if (o == m_lvl) begin
        if (m_seg + 1 > lim(m_lvl)) pe = 1;
        m_seg++;
      end else begin
        if (m_seg < lim(m_lvl)) pe = 1;
      end
    end
    if (ce)      c = 3;
    else if (pe) c = m_lvl ? 1 : 2;
    if (ce || pe) begin
      m_stage = 0;
      if (!m_err) m_code = c;
      m_err = 1;
      if (m_ecnt < 255) m_ecnt++;
    end else if (m_stage == 0) begin
      if (!o) m_stage = 1;
    end else if (m_stage == 1) begin
      if (o) begin
        m_stage = 2; m_lvl = 1; m_seg = 1;
      end
    end else if (o != m_lvl) begin
      m_lvl = o; m_seg = 1;
    end
    m_poe = o;
    m_pq  = qv;
    r.locked = (m_stage == 2);
    r.err    = m_err;
    r.code   = 2'(m_code);
    r.ecnt   = 8'(m_ecnt);
    r.wcnt   = 8'(m_wcnt);
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    n_cycle++;
    if (!reset && exp_fifo.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_fifo.pop_front();
      a = {locked, err, err_code, err_cnt, wrap_cnt};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard cycle %0d: got lk=%b e=%b c=%b ec=%0d wc=%0d want lk=%b e=%b c=%b ec=%0d wc=%0d",
                 n_cycle, a.locked, a.err, a.code, a.ecnt, a.wcnt,
                 e.locked, e.err, e.code, e.ecnt, e.wcnt);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit o, input int off);
    int qv;
    @(negedge clk);
    qv = (u_q + off) & 15;
    oe = o;
    q  = 4'(qv);
    exp_fifo.push_back(model(o, qv));
    if (o) u_q = (u_q + 1) & 15;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_zero", int'({locked, err, err_code, err_cnt, wrap_cnt}), 0);
    exp_fifo.delete();
    model_reset();
    u_q = 0;
    oe  = 1'b0;
    q   = 4'd0;
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic preamble();
    step(0, 0);
    repeat (2) begin
      step(1, 0); step(1, 0); step(1, 0);
      step(0, 0); step(0, 0);
    end
  endtask

  initial begin
    int pos;
    bit o;
    int off;
    reset = 1'b1;
    oe    = 1'b0;
    q     = 4'd0;
    model_reset();
    u_q = 0;
    #12;
    chk("reset_state", int'({locked, err, err_code, err_cnt, wrap_cnt}), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;

    // Clean stream, 48 enabled cycles
    step(0, 0);
    repeat (16) begin
      step(1, 0); step(1, 0); step(1, 0);
      step(0, 0); step(0, 0);
    end
    settle();
    chk("clean_locked", int'(locked), 1);
    chk("clean_err", int'(err), 0);
    chk("clean_err_cnt", int'(err_cnt), 0);
    chk("clean_wrap_cnt", int'(wrap_cnt), 3);

    // Long run then relock
    repeat (4) step(1, 0);
    settle();
    chk("long_run_err", int'(err), 1);
    chk("long_run_code", int'(err_code), 1);
    chk("long_run_cnt", int'(err_cnt), 1);
    chk("long_run_locked", int'(locked), 0);
    step(0, 0); step(1, 0);
    settle();
    chk("relock", int'(locked), 1);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);

    // Short pause
    do_reset();
    preamble();
    step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(1, 0);
    settle();
    chk("short_pause_code", int'(err_code), 2);
    chk("short_pause_locked", int'(locked), 0);

    // Count skip during a run
    do_reset();
    preamble();
    step(1, 0); step(1, 1);
    settle();
    chk("skip_run_code", int'(err_code), 3);
    chk("skip_run_cnt", int'(err_cnt), 1);

    // Count change during a pause
    do_reset();
    preamble();
    step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 1);
    settle();
    chk("skip_pause_code", int'(err_code), 3);

    // Simultaneous run + count error, then a later run error
    do_reset();
    preamble();
    step(1, 0); step(1, 0); step(1, 0); step(1, 1);
    settle();
    chk("simul_code", int'(err_code), 3);
    chk("simul_cnt", int'(err_cnt), 1);
    step(0, 0);
    repeat (4) step(1, 0);
    settle();
    chk("later_code", int'(err_code), 3);
    chk("later_cnt", int'(err_cnt), 2);

    // Reset mid-run and relock
    do_reset();
    preamble();
    step(1, 0); step(1, 0);
    do_reset();
    preamble();
    settle();
    chk("post_reset_locked", int'(locked), 1);
    chk("post_reset_err", int'(err), 0);

    // Saturation: one count error per two samples
    do_reset();
    repeat (300) begin
      step(0, 0);
      step(0, 1);
    end
    settle();
    chk("sat_err_cnt", int'(err_cnt), 255);
    repeat (4) begin
      step(0, 0);
      step(0, 1);
    end
    settle();
    chk("sat_hold", int'(err_cnt), 255);

    // Random mostly-correct stream with glitches
    do_reset();
    pos = 0;
    repeat (800) begin
      o = (pos % 5) == 0 || (pos % 5) == 4 ? 1'b0 : 1'b1;
      if ($urandom_range(0, 11) == 0) o = ~o;
      off = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 15)) : 0;
      step(o, off);
      pos++;
    end
    settle();
    chk("fifo_drained", exp_fifo.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
